prog_sequencer: RTL and testbench
=================================

// Module: prog_sequencer
// PURPOSE
//  Run-level controller for the PC/fetch datapath. Launches one of the three
//  resident programs (product, string match, closest pair), or all three in
//  order. Loads the PC with the program entry point and gates PC advance.
//  Detects program completion (halt) or timeout, records per-program cycle
//  counts and reports done. Sits between the test harness/top level and pc.
// PARAMETERS
//  PC_W    8      PC / entry-address width
//  CYC_W   16     cycle-counter width
//  MAX_CYC 4000   RUN cycles before timeout abort (must be < 2**CYC_W)
// PORTS
//  clk           in   1      clock
//  reset         in   1      asynchronous, active-high
//  start         in   1      launch request; sampled only in IDLE
//  sel           in   2      0=product 1=string match 2=closest pair 3=all in order
//  abort         in   1      force return to IDLE from any state
//  halt          in   1      decoder reports halt opcode executed this cycle
//  pc_load       out  1      pc loads pc_load_addr this cycle
//  pc_load_addr  out  PC_W   entry address of current program
//  pc_en         out  1      pc may advance (stall when 0)
//  prog_id       out  2      program currently loaded/running (0..2)
//  busy          out  1      high in every state except IDLE
//  done          out  1      one-cycle pulse at end of a completed run
//  timeout       out  1      sticky; set when any program hits MAX_CYC
//  last_cycles   out  CYC_W  RUN-cycle count of most recently finished program
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0; run_all=0.
//  States: IDLE, LOAD, RUN, DRAIN, FINISH (one-hot or binary, designer choice).
//  IDLE: pc_en=0. If start: prog_id<=(sel==3 ? 0 : sel), run_all<=(sel==3),
//    timeout<=0; go to LOAD. start while busy is ignored and not queued.
//  LOAD (exactly 1 cycle): pc_load=1; pc_load_addr=ENTRY[prog_id]; pc_en=0;
//    cycle counter cleared; go to RUN. halt in LOAD is ignored.
//  RUN: pc_en=1; counter increments every cycle, first RUN cycle counts as 1.
//    On halt: last_cycles<=counter; go to DRAIN.
//    Else if counter==MAX_CYC: timeout<=1, last_cycles<=MAX_CYC; go to DRAIN.
//    halt and limit in the same cycle: halt wins, timeout stays 0.
//  DRAIN (1 cycle): pc_en=0. If run_all and prog_id<2: prog_id++, go to LOAD.
//    Else go to FINISH.
//  FINISH: done=1 for exactly one cycle, busy=1; go to IDLE.
//  abort: highest priority in every non-IDLE state. Next state is IDLE;
//    pc_en=0 and pc_load=0 from the next cycle. No done pulse.
//    last_cycles and timeout keep their values. abort in IDLE does nothing.
//  Outputs pc_load, pc_en, busy and done are Moore, decoded from the state.
//  pc_load_addr is a combinational lookup of prog_id.
//  Latency: start accepted at cycle 0 -> pc_load at cycle 1 -> first pc_en
//    cycle at cycle 2.
//  Counter never wraps; the MAX_CYC check precedes any overflow.
// STRUCTURE
//  Shared package definitions: typedef enum seq_state_t
//    {IDLE, LOAD, RUN, DRAIN, FINISH}.
//  Entry constants: ENTRY_PRODUCT=0, ENTRY_STRMATCH=25, ENTRY_CLOSEST=44.
//  Also in the package: SEL_ALL=2'd3.
//  One sub-module: run_counter (clear, enable, count, at_limit). The FSM stays
//    in prog_sequencer.
//  pc is driven by pc_load/pc_en; no change to pc op/branch decode.
// TESTING
//  1. Reset mid-RUN -> all outputs 0 in the same cycle (async); IDLE after release.
//  2. start,sel=1; halt on 10th RUN cycle -> pc_load at cyc 1, addr=25.
//     Then last_cycles=10; done pulses once; busy low after it.
//  3. start,sel=3; halts after 5/7/9 RUN cycles -> loads 0, 25, 44 in order.
//     Each load is preceded by one DRAIN cycle with pc_en=0. One done pulse
//     only; last_cycles=9.
//  4. start,sel=2, no halt; MAX_CYC reduced to 20 -> timeout=1 after 20 RUN
//     cycles, last_cycles=20, done pulses.
//  5. abort in cycle 3 of RUN, with halt asserted in the same cycle -> IDLE.
//     No done; last_cycles unchanged.
//  6. start while busy, and halt during LOAD -> both ignored; sequence timing
//     is identical to scenario 2.

Source files
------------

// File: rtl/prog_sequencer_pkg.sv
// +----------------------------------------------------------------------+
// | prog_sequencer_pkg : shared states and program entry points          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package prog_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    FINISH = 3'd4
  } seq_state_t;

  localparam logic [1:0]  SEL_ALL        = 2'd3;
  localparam int unsigned ENTRY_PRODUCT  = 0;
  localparam int unsigned ENTRY_STRMATCH = 25;
  localparam int unsigned ENTRY_CLOSEST  = 44;

  function automatic int unsigned entry_of(input logic [1:0] id);
    case (id)
      2'd0:    entry_of = ENTRY_PRODUCT;
      2'd1:    entry_of = ENTRY_STRMATCH;
      2'd2:    entry_of = ENTRY_CLOSEST;
      default: entry_of = 0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/prog_sequencer_run_counter.sv
// +----------------------------------------------------------------------+
// | run_counter : RUN-cycle counter; count_o is the number of the current |
// | RUN cycle (first cycle after clear reads 1). Revision: 1.0            |
// +----------------------------------------------------------------------+
`default_nettype none

module run_counter #(
  parameter int CYC_W   = 16,
  parameter int MAX_CYC = 4000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [CYC_W-1:0] count_o,
  output logic             at_limit_o
);

  logic [CYC_W-1:0] count_q;

  assign count_o    = count_q + CYC_W'(1);
  assign at_limit_o = (count_o == CYC_W'(MAX_CYC));

  // Holding at the limit keeps the counter from ever wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && !at_limit_o) begin
      count_q <= count_o;
    end
  end

endmodule

`default_nettype wire

// File: rtl/prog_sequencer.sv
// +----------------------------------------------------------------------+
// | prog_sequencer : launches resident programs, gates PC, reports done  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module prog_sequencer
  import prog_sequencer_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int CYC_W   = 16,
  parameter int MAX_CYC = 4000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [1:0]       sel_i,
  input  logic             abort_i,
  input  logic             halt_i,
  output logic             pc_load_o,
  output logic [PC_W-1:0]  pc_load_addr_o,
  output logic             pc_en_o,
  output logic [1:0]       prog_id_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [CYC_W-1:0] last_cycles_o
);

  seq_state_t       state_q, state_d;
  logic [1:0]       prog_id_q, prog_id_d;
  logic             run_all_q, run_all_d;
  logic             timeout_q, timeout_d;
  logic [CYC_W-1:0] last_cycles_q, last_cycles_d;
  logic [CYC_W-1:0] w_count;
  logic             w_at_limit;

  run_counter #(
    .CYC_W   (CYC_W),
    .MAX_CYC (MAX_CYC)
  ) u_run_counter (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (state_q == LOAD),
    .enable_i   (state_q == RUN),
    .count_o    (w_count),
    .at_limit_o (w_at_limit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      prog_id_q     <= '0;
      run_all_q     <= 1'b0;
      timeout_q     <= 1'b0;
      last_cycles_q <= '0;
    end else begin
      state_q       <= state_d;
      prog_id_q     <= prog_id_d;
      run_all_q     <= run_all_d;
      timeout_q     <= timeout_d;
      last_cycles_q <= last_cycles_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    prog_id_d     = prog_id_q;
    run_all_d     = run_all_q;
    timeout_d     = timeout_q;
    last_cycles_d = last_cycles_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          prog_id_d = (sel_i == SEL_ALL) ? 2'd0 : sel_i;
          run_all_d = (sel_i == SEL_ALL);
          timeout_d = 1'b0;
          state_d   = LOAD;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        // Halt takes precedence over the limit in the same cycle.
        if (halt_i) begin
          last_cycles_d = w_count;
          state_d       = DRAIN;
        end else if (w_at_limit) begin
          timeout_d     = 1'b1;
          last_cycles_d = CYC_W'(MAX_CYC);
          state_d       = DRAIN;
        end
      end
      DRAIN: begin
        if (run_all_q && (prog_id_q < 2'd2)) begin
          prog_id_d = prog_id_q + 2'd1;
          state_d   = LOAD;
        end else begin
          state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort discards any pending update and returns straight to IDLE.
    if (abort_i && (state_q != IDLE)) begin
      state_d       = IDLE;
      prog_id_d     = prog_id_q;
      run_all_d     = run_all_q;
      timeout_d     = timeout_q;
      last_cycles_d = last_cycles_q;
    end
  end

  assign pc_load_o      = (state_q == LOAD);
  assign pc_en_o        = (state_q == RUN);
  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == FINISH);
  assign pc_load_addr_o = PC_W'(entry_of(prog_id_q));
  assign prog_id_o      = prog_id_q;
  assign timeout_o      = timeout_q;
  assign last_cycles_o  = last_cycles_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_sequencer.sv
// +----------------------------------------------------------------------+
// | tb_prog_sequencer : scoreboard bench with randomized program runs    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_prog_sequencer;

  localparam int PC_W  = 8;
  localparam int CYC_W = 16;
  localparam int MAXC  = 20;

  logic             clk = 1'b0;
  logic             reset, start_i, abort_i, halt_i;
  logic [1:0]       sel_i;
  logic             pc_load_o, pc_en_o, busy_o, done_o, timeout_o;
  logic [PC_W-1:0]  pc_load_addr_o;
  logic [1:0]       prog_id_o;
  logic [CYC_W-1:0] last_cycles_o;

  prog_sequencer #(.PC_W(PC_W), .CYC_W(CYC_W), .MAX_CYC(MAXC)) dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start_i),
    .sel_i          (sel_i),
    .abort_i        (abort_i),
    .halt_i         (halt_i),
    .pc_load_o      (pc_load_o),
    .pc_load_addr_o (pc_load_addr_o),
    .pc_en_o        (pc_en_o),
    .prog_id_o      (prog_id_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .timeout_o      (timeout_o),
    .last_cycles_o  (last_cycles_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int load_q[$];
  int len_q[$];
  int done_last_q[$];
  bit done_to_q[$];
  int model_last = 0;
  bit model_to   = 1'b0;
  bit mon_en     = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event with nothing expected", name);
  endtask

  function automatic int entry(input int p);
    return (p == 0) ? 0 : (p == 1) ? 25 : 44;
  endfunction

  // Monitor: pops expected events whenever the DUT presents one.
  int  run_cnt   = 0;
  bit  prev_done = 1'b0;
  int  m_p, m_len, m_last;
  bit  m_to;
  always @(negedge clk) begin
    if (!mon_en) begin
      run_cnt   = 0;
      prev_done = 1'b0;
    end else begin
      if (pc_load_o) begin
        if (load_q.size() == 0) fail_now("unexpected_load");
        else begin
          m_p = load_q.pop_front();
          chk("load_prog_id", prog_id_o, m_p);
          chk("load_addr", pc_load_addr_o, entry(m_p));
          chk("load_pc_en_low", pc_en_o, 0);
        end
      end
      if (pc_en_o) run_cnt++;
      else if (run_cnt > 0) begin
        if (len_q.size() == 0) fail_now("unexpected_run");
        else begin
          m_len = len_q.pop_front();
          chk("run_length", run_cnt, m_len);
        end
        run_cnt = 0;
      end
      if (done_o) begin
        if (done_last_q.size() == 0) fail_now("unexpected_done");
        else begin
          m_last = done_last_q.pop_front();
          m_to   = done_to_q.pop_front();
          chk("done_last_cycles", last_cycles_o, m_last);
          chk("done_timeout", timeout_o, m_to);
          chk("done_busy", busy_o, 1);
        end
      end
      if (prev_done) chk("busy_after_done", busy_o, 0);
      prev_done = done_o;
    end
  end

  // h values above MAXC mean the program never halts and times out.
  task automatic run_once(input int sel, input int h0, input int h1, input int h2,
                          input bit noise);
    int h[3];
    int progs[$];
    int cnt, guard, len;
    bit to;
    h[0] = h0; h[1] = h1; h[2] = h2;
    if (sel == 3) progs = '{0, 1, 2};
    else progs = '{sel};
    to = 1'b0;
    foreach (progs[i]) begin
      len = (h[i] > MAXC) ? MAXC : h[i];
      load_q.push_back(progs[i]);
      len_q.push_back(len);
      if (h[i] > MAXC) to = 1'b1;
      model_last = len;
    end
    done_last_q.push_back(model_last);
    done_to_q.push_back(to);
    model_to = to;

    @(negedge clk);
    sel_i   = 2'(sel);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("start_to_load_latency", pc_load_o, 1);
    halt_i = noise && ($urandom_range(0, 1) == 1);
    foreach (progs[i]) begin
      cnt = 0;
      for (guard = 0; guard < MAXC + 10; guard++) begin
        @(negedge clk);
        if (noise) begin
          start_i = ($urandom_range(0, 1) == 1);
          sel_i   = 2'($urandom_range(0, 3));
        end
        if (pc_en_o) begin
          cnt++;
          halt_i = (cnt == h[i]);
        end else begin
          halt_i = noise && pc_load_o && ($urandom_range(0, 1) == 1);
          if (cnt > 0) break;
        end
      end
      if (guard >= MAXC + 10) fail_now("run_wait_timeout");
    end
    start_i = 1'b0;
    halt_i  = 1'b0;
    for (guard = 0; guard < 10; guard++) begin
      if (!busy_o) break;
      @(negedge clk);
    end
    chk("idle_after_run", busy_o, 0);
    chk("idle_last_cycles", last_cycles_o, model_last);
    chk("idle_timeout", timeout_o, model_to);
  endtask

  initial begin
    reset = 1'b1; start_i = 1'b0; abort_i = 1'b0; halt_i = 1'b0; sel_i = 2'd0;
    #1;
    chk("reset_busy", busy_o, 0);
    chk("reset_pc_en", pc_en_o, 0);
    chk("reset_last_cycles", last_cycles_o, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_in_idle_busy", busy_o, 0);
    mon_en = 1'b1;

    run_once(1, 10, 0, 0, 1'b0);   // single program, halt on RUN cycle 10
    run_once(3, 5, 7, 9, 1'b0);    // all three in order
    run_once(2, 99, 0, 0, 1'b0);   // no halt -> timeout
    run_once(0, MAXC, 0, 0, 1'b0); // halt on limit cycle: no timeout
    run_once(1, 10, 0, 0, 1'b1);   // start while busy and halt in LOAD ignored
    for (int r = 0; r < 12; r++)
      run_once(int'($urandom_range(0, 3)), int'($urandom_range(1, MAXC + 2)),
               int'($urandom_range(1, MAXC + 2)), int'($urandom_range(1, MAXC + 2)),
               ($urandom_range(0, 1) == 1));

    // Abort with halt on RUN cycle 3: back to IDLE, no done, results held.
    load_q.push_back(0);
    len_q.push_back(3);
    @(negedge clk);
    sel_i = 2'd0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_setup_in_run", pc_en_o, 1);
    abort_i = 1'b1; halt_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0; halt_i = 1'b0;
    chk("abort_busy", busy_o, 0);
    chk("abort_pc_en", pc_en_o, 0);
    chk("abort_pc_load", pc_load_o, 0);
    chk("abort_last_cycles", last_cycles_o, model_last);
    chk("abort_timeout", timeout_o, model_to);
    repeat (4) @(negedge clk);

    // Asynchronous reset in the middle of RUN.
    mon_en = 1'b0;
    sel_i = 2'd2; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_setup_in_run", pc_en_o, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_pc_en", pc_en_o, 0);
    chk("rst_async_busy", busy_o, 0);
    chk("rst_async_pc_load", pc_load_o, 0);
    chk("rst_async_prog_id", prog_id_o, 0);
    chk("rst_async_addr", pc_load_addr_o, 0);
    chk("rst_async_last_cycles", last_cycles_o, 0);
    chk("rst_async_timeout", timeout_o, 0);
    chk("rst_async_done", done_o, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_release_idle", busy_o, 0);
    model_last = 0;
    model_to   = 1'b0;
    load_q.delete(); len_q.delete(); done_last_q.delete(); done_to_q.delete();
    mon_en = 1'b1;
    run_once(0, 4, 0, 0, 1'b0);

    repeat (3) @(negedge clk);
    chk("leftover_loads", load_q.size(), 0);
    chk("leftover_runs", len_q.size(), 0);
    chk("leftover_dones", done_last_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
